pc_fetch: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the RISC-V core.
- Holds the current PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers the returned instruction until the decode side accepts it.
- Loads the next PC from the next-PC logic (npc_i) on acceptance; a flush redirects fetch to flush_pc.

---
 rtl/pc_fetch.sv | 99 +++++++++
 tb/tb_pc_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and single-outstanding instruction fetch sequencer; best case 1 inst / 3 cycles, stalls on imem_req_ready and inst_ready.
// Optional macro PCF_MISALIGN_CHK_EN: misaligned PCs yield a NOP with inst_misalign instead of a memory request.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_i,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc_o,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        inst_misalign
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t state;

  logic misalign;
  logic req_fire;

`ifdef PCF_MISALIGN_CHK_EN
  assign misalign = (pc_o[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign imem_req_addr  = pc_o;
  assign imem_req_valid = (state == S_REQ) && !misalign;
  assign req_fire       = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      pc_o          <= RESET_PC;
      inst_pc       <= RESET_PC;
      inst_o        <= NOP_INST;
      inst_valid    <= 1'b0;
      inst_misalign <= 1'b0;
    end else if (flush) begin
      pc_o          <= flush_pc;
      inst_valid    <= 1'b0;
      inst_misalign <= 1'b0;
      // A request accepted by memory leaves a response to swallow in S_DROP.
      case (state)
        S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_DROP;
        S_REQ:   state <= req_fire ? S_DROP : S_REQ;
        S_DROP:  state <= imem_rsp_valid ? S_REQ : S_DROP;
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (misalign) begin
            inst_o        <= NOP_INST;
            inst_pc       <= pc_o;
            inst_misalign <= 1'b1;
            inst_valid    <= 1'b1;
            state         <= S_HOLD;
          end else if (imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_o        <= imem_rsp_data;
            inst_pc       <= pc_o;
            inst_valid    <= 1'b1;
            inst_misalign <= 1'b0;
            state         <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            pc_o          <= npc_i;
            inst_valid    <= 1'b0;
            inst_misalign <= 1'b0;
            state         <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus a randomized run against a transaction-level model.
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc_i = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] pc_o;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_o;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        inst_misalign;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PCF_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  pc_fetch dut (
    .clk(clk), .rst(rst), .npc_i(npc_i), .flush(flush), .flush_pc(flush_pc), .pc_o(pc_o),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_o(inst_o), .inst_pc(inst_pc), .inst_ready(inst_ready), .inst_misalign(inst_misalign)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] nxt(input logic [31:0] pc);
    return (pc[4:2] == 3'd7) ? pc + 32'h44 : pc + 32'h4;
  endfunction

  // Assert reset, then release it and advance to the first request cycle.
  task automatic do_reset;
    rst = 1'b1; flush = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp += 6;
    if (pc_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
    if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc: got %h want %h", inst_pc, 32'h0); end
    if (inst_o !== NOP) begin n_err++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP); end
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    if (inst_misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", inst_misalign); end
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req_valid); end
  endtask

  task automatic test_basic;
    imem_req_ready = 1'b1; inst_ready = 1'b1; npc_i = 32'h4;
    rst = 1'b0;
    tick();
    n_cmp += 2;
    if (imem_req_valid !== 1'b1) begin n_err++; $display("FAIL basic_req_valid: got %b want 1", imem_req_valid); end
    if (imem_req_addr !== 32'h0) begin n_err++; $display("FAIL basic_req_addr: got %h want 0", imem_req_addr); end
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093; inst_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL basic_wait_req: got %b want 0", imem_req_valid); end
    tick();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b1;
    n_cmp += 3;
    if (inst_valid !== 1'b1) begin n_err++; $display("FAIL basic_inst_valid: got %b want 1", inst_valid); end
    if (inst_o !== 32'h0050_0093) begin n_err++; $display("FAIL basic_inst: got %h want 00500093", inst_o); end
    if (inst_pc !== 32'h0) begin n_err++; $display("FAIL basic_inst_pc: got %h want 0", inst_pc); end
    tick();
    inst_ready = 1'b0;
    n_cmp += 3;
    if (pc_o !== 32'h4) begin n_err++; $display("FAIL basic_next_pc: got %h want 4", pc_o); end
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_err++; $display("FAIL basic_second_req: got %b/%h want 1/4", imem_req_valid, imem_req_addr); end
    if (inst_valid !== 1'b0) begin n_err++; $display("FAIL basic_consumed: got %b want 0", inst_valid); end
  endtask

  task automatic test_req_stall;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_err++; $display("FAIL req_stall_%0d: got %b/%h want 1/0", i, imem_req_valid, imem_req_addr); end
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL req_stall_accept: got %b want 0", imem_req_valid); end
  endtask

  task automatic test_hold_stall;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1234_5678;
    tick();
    imem_rsp_valid = 1'b0; inst_ready = 1'b0; npc_i = 32'h8;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_o !== 32'h1234_5678 || inst_pc !== 32'h0 || pc_o !== 32'h0 || imem_req_valid !== 1'b0)
        begin n_err++; $display("FAIL hold_stall_%0d: got v=%b i=%h ipc=%h pc=%h rq=%b want 1/12345678/0/0/0", i, inst_valid, inst_o, inst_pc, pc_o, imem_req_valid); end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (pc_o !== 32'h8 || inst_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got pc=%h v=%b want 8/0", pc_o, inst_valid); end
  endtask

  task automatic test_flush_wait;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; flush = 1'b1; flush_pc = 32'h80;
    tick();
    flush = 1'b0;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_o !== 32'h80) begin n_err++; $display("FAIL flush_wait_drop: got v=%b rq=%b pc=%h want 0/0/80", inst_valid, imem_req_valid, pc_o); end
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp += 2;
    if (inst_valid !== 1'b0 || inst_o === 32'hDEAD_BEEF) begin n_err++; $display("FAIL flush_wait_stale: got v=%b inst=%h want 0/not deadbeef", inst_valid, inst_o); end
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin n_err++; $display("FAIL flush_wait_redirect: got %b/%h want 1/80", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_flush_hold;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_1111;
    tick();
    imem_rsp_valid = 1'b0; inst_ready = 1'b1; npc_i = 32'h10; flush = 1'b1; flush_pc = 32'h40;
    tick();
    inst_ready = 1'b0; flush = 1'b0;
    n_cmp += 2;
    if (pc_o !== 32'h40) begin n_err++; $display("FAIL flush_hold_pc: got %h want 40", pc_o); end
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin n_err++; $display("FAIL flush_hold_state: got v=%b rq=%b want 0/1", inst_valid, imem_req_valid); end
  endtask

  task automatic test_misalign;
    flush = 1'b1; flush_pc = 32'h42;
    tick();
    flush = 1'b0;
    if (CHK) begin
      n_cmp++;
      if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL misalign_noreq: got %b want 0", imem_req_valid); end
      tick();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_o !== NOP || inst_misalign !== 1'b1 || inst_pc !== 32'h42)
        begin n_err++; $display("FAIL misalign_nop: got v=%b i=%h m=%b pc=%h want 1/13/1/42", inst_valid, inst_o, inst_misalign, inst_pc); end
    end else begin
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h42 || inst_misalign !== 1'b0)
        begin n_err++; $display("FAIL misalign_issue: got rq=%b a=%h m=%b want 1/42/0", imem_req_valid, imem_req_addr, inst_misalign); end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_2222;
      tick();
      imem_rsp_valid = 1'b0;
    end
    inst_ready = 1'b1; npc_i = 32'h44;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (inst_misalign !== 1'b0 || pc_o !== 32'h44) begin n_err++; $display("FAIL misalign_consume: got m=%b pc=%h want 0/44", inst_misalign, pc_o); end
  endtask

  // Randomized traffic: memory with 1-3 cycle latency, random stalls and flushes.
  task automatic test_random;
    logic [31:0] m_pc, mem_addr, exp_i;
    bit mem_pend;
    int mem_cnt, n_deliv;
    bit exp_m;
    do_reset();
    m_pc = 32'h0; mem_pend = 0; mem_cnt = 0; mem_addr = '0; n_deliv = 0;
    for (int i = 0; i < 3000; i++) begin
      imem_rsp_valid = 1'b0;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin imem_rsp_valid = 1'b1; imem_rsp_data = inst_of(mem_addr); mem_pend = 0; end
      end
      n_cmp++;
      if (pc_o !== m_pc) begin n_err++; $display("FAIL rand_pc @%0d: got %h want %h", i, pc_o, m_pc); end
      if (inst_valid) begin
        n_cmp++;
        if (inst_pc !== m_pc) begin n_err++; $display("FAIL rand_inst_pc @%0d: got %h want %h", i, inst_pc, m_pc); end
      end
      if (imem_req_valid) begin
        n_cmp++;
        if (imem_req_addr !== m_pc || (CHK && m_pc[1:0] != 2'b00)) begin n_err++; $display("FAIL rand_req_addr @%0d: got %h want %h aligned", i, imem_req_addr, m_pc); end
      end
      imem_req_ready = ($urandom_range(0, 2) != 0);
      inst_ready = ($urandom_range(0, 1) != 0);
      flush = ($urandom_range(0, 24) == 0);
      flush_pc = ($urandom_range(0, 1023) << 2) | (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      npc_i = nxt(pc_o);
      if (imem_req_valid && imem_req_ready) begin
        mem_pend = 1; mem_cnt = $urandom_range(1, 3); mem_addr = imem_req_addr;
      end
      if (flush) m_pc = flush_pc;
      else if (inst_valid && inst_ready) begin
        exp_m = CHK && (m_pc[1:0] != 2'b00);
        exp_i = exp_m ? NOP : inst_of(m_pc);
        n_cmp++;
        if (inst_o !== exp_i || inst_misalign !== exp_m) begin n_err++; $display("FAIL rand_inst @%0d: got %h/%b want %h/%b", i, inst_o, inst_misalign, exp_i, exp_m); end
        n_deliv++;
        m_pc = nxt(m_pc);
      end
      tick();
    end
    flush = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    n_cmp++;
    if (n_deliv < 150) begin n_err++; $display("FAIL rand_progress: got %0d deliveries want >= 150", n_deliv); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_hold_stall();
    test_flush_wait();
    test_flush_hold();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
